// File: rtl/io_cmd_pkg.sv
// Shared FSM state encoding and protocol byte constants for the UART-driven IO bus master.
package io_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        ADDR   = 3'd1,
        DATA   = 3'd2,
        STROBE = 3'd3,
        WAIT   = 3'd4,
        RESP   = 3'd5
    } state_e;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_OK  = 8'h4B;
    localparam logic [7:0] RSP_ERR = 8'h45;

endpackage

// File: rtl/io_bus_cmd_master.sv
// Byte-command driven IO bus initiator: strobe one cycle after the last frame byte, reply from the cycle after io_ready.
// Response bytes are pushed only while tx_full is low; rx bytes arriving outside a frame-receive state are dropped.
module io_bus_cmd_master
    import io_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT   = 1024,
    parameter int unsigned GAP_LIMIT = 1_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    input  logic        tx_full,
    output logic        tx_wr,
    output logic [7:0]  tx_data,
    output logic        io_addr_strobe,
    output logic        io_read_strobe,
    output logic        io_write_strobe,
    output logic [3:0]  io_byte_enable,
    output logic [31:0] io_address,
    output logic [31:0] io_write_data,
    input  logic [31:0] io_read_data,
    input  logic        io_ready,
    output logic        busy
);

    localparam int TW = (TIMEOUT > 1)   ? $clog2(TIMEOUT)   : 1;
    localparam int GW = (GAP_LIMIT > 1) ? $clog2(GAP_LIMIT) : 1;

    state_e        state_q, state_d;
    logic          is_wr_q, is_wr_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [31:0]   resp_q, resp_d;
    logic [1:0]    byte_cnt_q, byte_cnt_d;
    logic [TW-1:0] to_cnt_q, to_cnt_d;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;

    always_comb begin
        state_d    = state_q;
        is_wr_d    = is_wr_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        resp_d     = resp_q;
        byte_cnt_d = byte_cnt_q;
        to_cnt_d   = '0;
        gap_cnt_d  = '0;
        case (state_q)
            IDLE: begin
                if (rx_valid && (rx_data == OP_WR || rx_data == OP_RD)) begin
                    is_wr_d    = (rx_data == OP_WR);
                    byte_cnt_d = 2'd0;
                    state_d    = ADDR;
                end
            end
            ADDR, DATA: begin
                if (rx_valid) begin
                    if (state_q == ADDR) addr_d  = {addr_q[23:0], rx_data};
                    else                 wdata_d = {wdata_q[23:0], rx_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3)
                        state_d = (state_q == ADDR && is_wr_q) ? DATA : STROBE;
                end else if (gap_cnt_q == GW'(GAP_LIMIT - 1)) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GW'(1);
                end
            end
            STROBE: begin
                // counter is zero here, so it equals cycles-since-strobe during WAIT
                to_cnt_d = to_cnt_q + TW'(1);
                state_d  = WAIT;
            end
            WAIT: begin
                if (io_ready) begin
                    resp_d     = is_wr_q ? {RSP_OK, 24'h0} : io_read_data;
                    byte_cnt_d = is_wr_q ? 2'd0 : 2'd3;
                    state_d    = RESP;
                end else if (to_cnt_q == TW'(TIMEOUT - 1)) begin
                    resp_d     = {RSP_ERR, 24'h0};
                    byte_cnt_d = 2'd0;
                    state_d    = RESP;
                end else begin
                    to_cnt_d = to_cnt_q + TW'(1);
                end
            end
            RESP: begin
                if (!tx_full) begin
                    resp_d = {resp_q[23:0], 8'h0};
                    if (byte_cnt_q == 2'd0) state_d = IDLE;
                    else                    byte_cnt_d = byte_cnt_q - 2'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            is_wr_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            resp_q     <= '0;
            byte_cnt_q <= '0;
            to_cnt_q   <= '0;
            gap_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            is_wr_q    <= is_wr_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            resp_q     <= resp_d;
            byte_cnt_q <= byte_cnt_d;
            to_cnt_q   <= to_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
        end
    end

    assign busy            = (state_q != IDLE);
    assign io_addr_strobe  = (state_q == STROBE);
    assign io_read_strobe  = (state_q == STROBE) && !is_wr_q;
    assign io_write_strobe = (state_q == STROBE) && is_wr_q;
    assign io_byte_enable  = (state_q == STROBE) ? 4'hF : 4'h0;
    assign io_address      = addr_q;
    assign io_write_data   = wdata_q;
    assign tx_wr           = (state_q == RESP) && !tx_full;
    assign tx_data         = (state_q == RESP) ? resp_q[31:24] : 8'h0;

endmodule

// File: tb/tb_io_bus_cmd_master.sv
module tb_io_bus_cmd_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        tx_full;
    logic        tx_wr;
    logic [7:0]  tx_data;
    logic        io_addr_strobe, io_read_strobe, io_write_strobe;
    logic [3:0]  io_byte_enable;
    logic [31:0] io_address, io_write_data, io_read_data;
    logic        io_ready;
    logic        busy;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } bexp_t;

    typedef struct {
        logic        is_wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          dly;       // io_ready cycles after strobe, -1 = never
        logic [31:0] rdata;
        int          gap;       // idle cycles between frame bytes
        logic [31:0] exp_resp;  // expected reply bytes, MSB first
        int          exp_n;
    } vec_t;

    logic [7:0] exp_tx[$];
    bexp_t      exp_bus[$];

    io_bus_cmd_master #(.TIMEOUT(16), .GAP_LIMIT(50)) dut (
        .clk(clk), .reset(reset),
        .rx_data(rx_data), .rx_valid(rx_valid),
        .tx_full(tx_full), .tx_wr(tx_wr), .tx_data(tx_data),
        .io_addr_strobe(io_addr_strobe), .io_read_strobe(io_read_strobe),
        .io_write_strobe(io_write_strobe), .io_byte_enable(io_byte_enable),
        .io_address(io_address), .io_write_data(io_write_data),
        .io_read_data(io_read_data), .io_ready(io_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset) begin
            if (tx_wr) begin
                chk("tx_while_full", {31'h0, tx_full}, 32'h0);
                chk("tx_expected", {31'h0, exp_tx.size() > 0}, 32'h1);
                if (exp_tx.size() > 0) chk("tx_byte", {24'h0, tx_data}, {24'h0, exp_tx.pop_front()});
            end
            if (io_addr_strobe) begin
                chk("bus_expected", {31'h0, exp_bus.size() > 0}, 32'h1);
                if (exp_bus.size() > 0) begin
                    bexp_t e;
                    e = exp_bus.pop_front();
                    chk("wr_strobe", {31'h0, io_write_strobe}, {31'h0, e.wr});
                    chk("rd_strobe", {31'h0, io_read_strobe}, {31'h0, !e.wr});
                    chk("byte_en", {28'h0, io_byte_enable}, 32'hF);
                    chk("bus_addr", io_address, e.addr);
                    if (e.wr) chk("bus_wdata", io_write_data, e.data);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h0;
    endtask

    task automatic wait_idle;
        for (int k = 0; k < 40 && busy; k++) tick();
        chk("idle", {31'h0, busy}, 32'h0);
        chk("txq_empty", exp_tx.size(), 0);
        chk("busq_empty", exp_bus.size(), 0);
    endtask

    task automatic run_frame(input vec_t v);
        logic [7:0] fb[9];
        int nb;
        int found;
        bexp_t e;
        logic [31:0] r;
        fb[0] = v.is_wr ? 8'h57 : 8'h52;
        for (int i = 0; i < 4; i++) fb[1+i] = v.addr[31-8*i -: 8];
        for (int i = 0; i < 4; i++) fb[5+i] = v.wdata[31-8*i -: 8];
        nb = v.is_wr ? 9 : 5;
        e.wr = v.is_wr; e.addr = v.addr; e.data = v.wdata;
        exp_bus.push_back(e);
        r = v.exp_resp;
        for (int i = 0; i < v.exp_n; i++) exp_tx.push_back(r[31-8*i -: 8]);
        for (int i = 0; i < nb; i++) begin
            send_byte(fb[i]);
            if (i != nb - 1) for (int g = 0; g < v.gap; g++) tick();
        end
        @(negedge clk);
        chk("strobe_lat", {31'h0, io_addr_strobe}, 32'h1);
        if (v.dly >= 0) begin
            tick();
            for (int i = 1; i < v.dly; i++) tick();
            chk("addr_hold", io_address, v.addr);
            io_ready     = 1'b1;
            io_read_data = v.rdata;
            tick();
            io_ready     = 1'b0;
            io_read_data = 32'h0;
            @(negedge clk);
            chk("tx_lat", {31'h0, tx_wr}, 32'h1);
        end else begin
            found = 0;
            for (int k = 1; k <= 40 && found == 0; k++) begin
                tick();
                @(negedge clk);
                if (tx_wr) found = k;
            end
            chk("timeout_lat", found, 16);
        end
        wait_idle();
    endtask

    vec_t vt[6];

    initial begin
        vt[0] = '{1'b1, 32'hC000_0004, 32'h0000_1234, 3,  32'h0,         0,  32'h4B00_0000, 1};
        vt[1] = '{1'b0, 32'hC000_0100, 32'h0,         1,  32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 4};
        vt[2] = '{1'b0, 32'h1234_5678, 32'h0,         -1, 32'h0,         2,  32'h4500_0000, 1};
        vt[3] = '{1'b1, 32'hFFFF_FFFC, 32'hA5A5_5A5A, -1, 32'h0,         0,  32'h4500_0000, 1};
        vt[4] = '{1'b0, 32'h0000_0000, 32'h0,         15, 32'h8000_0001, 0,  32'h8000_0001, 4};
        vt[5] = '{1'b1, 32'h0000_0001, 32'hFEDC_BA98, 14, 32'h0,         49, 32'h4B00_0000, 1};

        reset = 1'b1; rx_data = 8'h0; rx_valid = 1'b0; tx_full = 1'b0;
        io_ready = 1'b0; io_read_data = 32'h0;
        #2;
        chk("rst_addr", io_address, 32'h0);
        chk("rst_wdata", io_write_data, 32'h0);
        chk("rst_ctl", {14'h0, tx_wr, tx_data, io_addr_strobe, io_read_strobe,
                        io_write_strobe, io_byte_enable, busy}, 32'h0);
        tick(); tick();
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) run_frame(vt[i]);

        // back-pressure: reply held off by tx_full for 10 cycles
        begin
            bexp_t e;
            int n;
            e.wr = 1'b0; e.addr = 32'hC000_0200; e.data = 32'h0;
            exp_bus.push_back(e);
            exp_tx.push_back(8'h01); exp_tx.push_back(8'h02);
            exp_tx.push_back(8'h03); exp_tx.push_back(8'h04);
            send_byte(8'h52); send_byte(8'hC0); send_byte(8'h00);
            send_byte(8'h02); send_byte(8'h00);
            @(negedge clk);
            chk("bp_strobe", {31'h0, io_addr_strobe}, 32'h1);
            tick();
            tx_full = 1'b1;
            io_ready = 1'b1; io_read_data = 32'h0102_0304;
            tick();
            io_ready = 1'b0; io_read_data = 32'h0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                chk("bp_hold", {31'h0, tx_wr}, 32'h0);
                tick();
            end
            tx_full = 1'b0;
            n = 0;
            for (int k = 0; k < 10; k++) begin
                @(negedge clk);
                if (tx_wr) n++;
                tick();
            end
            chk("bp_count", n, 4);
            wait_idle();
        end

        // garbage and an abandoned frame are discarded by the gap timeout
        send_byte(8'h00); send_byte(8'hFF);
        chk("garbage_idle", {31'h0, busy}, 32'h0);
        send_byte(8'h57); send_byte(8'hC0);
        chk("partial_busy", {31'h0, busy}, 32'h1);
        for (int k = 0; k < 60; k++) tick();
        chk("gap_resync", {31'h0, busy}, 32'h0);
        run_frame(vt[0]);

        // reset while waiting for io_ready
        begin
            bexp_t e;
            e.wr = 1'b0; e.addr = 32'h0000_0ABC; e.data = 32'h0;
            exp_bus.push_back(e);
            send_byte(8'h52); send_byte(8'h00); send_byte(8'h00);
            send_byte(8'h0A); send_byte(8'hBC);
            @(negedge clk);
            chk("rst_strobe", {31'h0, io_addr_strobe}, 32'h1);
            tick(); tick();
            chk("rst_in_wait", {31'h0, busy}, 32'h1);
            reset = 1'b1;
            #1;
            chk("arst_addr", io_address, 32'h0);
            chk("arst_ctl", {14'h0, tx_wr, tx_data, io_addr_strobe, io_read_strobe,
                             io_write_strobe, io_byte_enable, busy}, 32'h0);
            tick(); tick(); tick();
            reset = 1'b0;
            io_ready = 1'b1; io_read_data = 32'h1111_2222;
            tick();
            io_ready = 1'b0; io_read_data = 32'h0;
            for (int k = 0; k < 20; k++) tick();
            wait_idle();
            run_frame(vt[1]);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
